// File: rtl/sad_pkg.sv
// Shared types, default parameters and helpers for the windowed
// sum-of-absolute-differences accumulator.
package sad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } sad_state_e;

    localparam int unsigned DefPixW = 8;
    localparam int unsigned DefWinW = 11;
    localparam int unsigned DefWinH = 11;
    localparam int unsigned DefSumW = 16;

    function automatic int unsigned sad_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                res = res + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference of two pixels.
module abs_diff #(
    parameter int unsigned PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] diff_o
);

    always_comb begin
        diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    end

endmodule

// File: rtl/window_sad_acc.sv
// Accumulates |pix_a - pix_b| over fixed-size windows framed by in_first and
// presents a registered sum plus threshold hit flag through a valid/ready port.
module window_sad_acc
    import sad_pkg::*;
#(
    parameter int unsigned PIX_W = DefPixW,
    parameter int unsigned WIN_W = DefWinW,
    parameter int unsigned WIN_H = DefWinH,
    parameter int unsigned SUM_W = DefSumW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    input  logic [SUM_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_hit,
    output logic             sync_err
);

    localparam int unsigned N       = WIN_W * WIN_H;
    localparam int unsigned CntW    = sad_clog2(N + 1);
    localparam bit          OneBeat = (N == 1);

    generate
        if (SUM_W < PIX_W + sad_clog2(N)) begin : g_sum_w_too_small
            $error("window_sad_acc: SUM_W too small for PIX_W and window size");
        end
    endgenerate

    sad_state_e       state_q;
    logic [SUM_W-1:0] acc_q;
    logic [CntW-1:0]  count_q;
    logic [SUM_W-1:0] thr_q;
    logic             out_valid_q;
    logic [SUM_W-1:0] out_sum_q;
    logic             out_hit_q;
    logic             sync_err_q;

    logic [PIX_W-1:0] diff;
    logic [SUM_W-1:0] diff_ext;
    logic [SUM_W-1:0] acc_d;
    logic [CntW-1:0]  count_d;
    logic             accept;
    logic             start_win;
    logic             extend;
    logic             last_beat;
    logic             sync_err_d;

    abs_diff #(
        .PIX_W (PIX_W)
    ) u_abs_diff (
        .a_i    (pix_a),
        .b_i    (pix_b),
        .diff_o (diff)
    );

    always_comb begin
        in_ready  = (state_q != StDone) || out_ready;
        accept    = in_valid && in_ready;
        diff_ext  = SUM_W'(diff);
        acc_d     = acc_q + diff_ext;
        count_d   = count_q + 1'b1;
        last_beat = (count_d == CntW'(N));
        // A first beat always opens a window; in DONE accept implies the result is consumed.
        start_win = accept && in_first;
        extend    = accept && !in_first && (state_q == StAccum);
        if (state_q == StAccum) begin
            sync_err_d = accept && in_first;
        end else begin
            sync_err_d = accept && !in_first;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_hit_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
            if (start_win) begin
                acc_q   <= diff_ext;
                count_q <= CntW'(1);
                thr_q   <= threshold;
                if (OneBeat) begin
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                    out_sum_q   <= diff_ext;
                    out_hit_q   <= (diff_ext > threshold);
                end else begin
                    state_q     <= StAccum;
                    out_valid_q <= 1'b0;
                end
            end else if (extend) begin
                acc_q   <= acc_d;
                count_q <= count_d;
                if (last_beat) begin
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                    out_sum_q   <= acc_d;
                    out_hit_q   <= (acc_d > thr_q);
                end
            end else if ((state_q == StDone) && out_ready) begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_hit   = out_hit_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_window_sad_acc.sv
// Directed self-checking bench: default 11x11 instance plus a 2x2 instance.
module tb_window_sad_acc;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic [7:0]  pix_a;
    logic [7:0]  pix_b;
    logic [15:0] threshold;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_hit;
    logic        sync_err;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_in_first;
    logic [7:0]  s_pix_a;
    logic [7:0]  s_pix_b;
    logic [9:0]  s_threshold;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [9:0]  s_out_sum;
    logic        s_out_hit;
    logic        s_sync_err;

    int checks;
    int errors;

    window_sad_acc u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .pix_a     (pix_a),
        .pix_b     (pix_b),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_hit   (out_hit),
        .sync_err  (sync_err)
    );

    window_sad_acc #(
        .PIX_W (8),
        .WIN_W (2),
        .WIN_H (2),
        .SUM_W (10)
    ) u_dut_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_first  (s_in_first),
        .pix_a     (s_pix_a),
        .pix_b     (s_pix_b),
        .threshold (s_threshold),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_hit   (s_out_hit),
        .sync_err  (s_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed_window(input int a, input int b, input int n, input int thr0,
                               input int thr_mid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) check("pre_last_valid", {31'd0, out_valid}, 32'd0);
            in_valid  = 1'b1;
            in_first  = (i == 0);
            pix_a     = 8'(a);
            pix_b     = 8'(b);
            threshold = (i == 0) ? 16'(thr0) : 16'(thr_mid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic check_result(input string tag, input int sum, input int hit);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, out_sum}, 32'(sum));
        check({tag, "_hit"}, {31'd0, out_hit}, 32'(hit));
        check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, out_ready});
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_first    = 1'b0;
        pix_a       = '0;
        pix_b       = '0;
        threshold   = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_first  = 1'b0;
        s_pix_a     = '0;
        s_pix_b     = '0;
        s_threshold = '0;
        s_out_ready = 1'b0;

        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, out_sum}, 32'd0);
        check("rst_hit", {31'd0, out_hit}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // 121 x |200-100| = 12100 > 12000
        feed_window(200, 100, 121, 12000, 0);
        check_result("w1", 12100, 1);
        consume("w1");

        // Equal to threshold is not a hit; mid-window threshold of 0 must be ignored
        feed_window(200, 100, 121, 12100, 0);
        check_result("w1b", 12100, 0);
        consume("w1b");

        // Max per-beat difference: 121 x 255 = 30855
        feed_window(0, 255, 121, 0, 0);
        check_result("w2", 30855, 1);
        consume("w2");

        // Restart at beat 50: only the 121 beats of |3-1| = 2 count -> 242
        for (int i = 0; i < 171; i++) begin
            @(negedge clk);
            if (i == 51) check("restart_sync_err", {31'd0, sync_err}, 32'd1);
            if (i == 52) check("restart_sync_clr", {31'd0, sync_err}, 32'd0);
            in_valid  = 1'b1;
            in_first  = (i == 0) || (i == 50);
            pix_a     = (i < 50) ? 8'd10 : 8'd3;
            pix_b     = (i < 50) ? 8'd0 : 8'd1;
            threshold = (i < 50) ? 16'd1000 : 16'd241;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        check_result("w3", 242, 1);

        // Stall: result must hold and no beat may be accepted
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_sum", {16'd0, out_sum}, 32'd242);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
        end

        // Back-to-back window starting on the consuming edge: 121 x |5-7| = 242 > 200
        out_ready = 1'b1;
        feed_window(5, 7, 121, 200, 0);
        check_result("w4", 242, 1);
        check("w4_sync_err", {31'd0, sync_err}, 32'd0);
        @(negedge clk);
        check("w4_consumed", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset asserted mid-window clears outputs without a clock edge
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_first  = (i == 0);
            pix_a     = 8'd1;
            pix_b     = 8'd0;
            threshold = 16'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        check("pre_rst_sum", {16'd0, out_sum}, 32'd242);
        reset = 1'b1;
        #1;
        check("async_rst_sum", {16'd0, out_sum}, 32'd0);
        check("async_rst_hit", {31'd0, out_hit}, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_first = 1'b0;
        @(negedge clk);
        check("drop_sync_err", {31'd0, sync_err}, 32'd1);
        check("drop_no_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_sync_clr", {31'd0, sync_err}, 32'd0);

        // Fresh window after reset: 121 x 3 = 363 > 362
        feed_window(4, 1, 121, 362, 0);
        check_result("w5", 363, 1);
        consume("w5");

        // 2x2 instance: diffs 1,2,3,4 (two with b>a) -> 10 > 9
        sa[0] = 8'd5;  sb[0] = 8'd4;
        sa[1] = 8'd10; sb[1] = 8'd12;
        sa[2] = 8'd3;  sb[2] = 8'd6;
        sa[3] = 8'd20; sb[3] = 8'd16;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) check("small_pre_valid", {31'd0, s_out_valid}, 32'd0);
            s_in_valid  = 1'b1;
            s_in_first  = (i == 0);
            s_pix_a     = sa[i];
            s_pix_b     = sb[i];
            s_threshold = 10'd9;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_first = 1'b0;
        check("small_valid", {31'd0, s_out_valid}, 32'd1);
        check("small_sum", {22'd0, s_out_sum}, 32'd10);
        check("small_hit", {31'd0, s_out_hit}, 32'd1);

        // Full-scale 2x2 window 4 x 255 = 1020, not above threshold 1020
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_in_valid  = 1'b1;
            s_in_first  = (i == 0);
            s_pix_a     = 8'd255;
            s_pix_b     = 8'd0;
            s_threshold = 10'd1020;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_first = 1'b0;
        check("small_max_valid", {31'd0, s_out_valid}, 32'd1);
        check("small_max_sum", {22'd0, s_out_sum}, 32'd1020);
        check("small_max_hit", {31'd0, s_out_hit}, 32'd0);
        @(negedge clk);
        check("small_consumed", {31'd0, s_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_sad_acc.md
WINDOW_SAD_ACC -- requirements
Module: window_sad_acc

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter WIN_W, default 11, window width in pixels.
REQ-003 Parameter WIN_H, default 11, window height in pixels; N = WIN_W*WIN_H beats per window.
REQ-004 Parameter SUM_W, default 16, accumulator/result width; elaboration SHALL fail if SUM_W < PIX_W + clog2(N).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  beat present.
REQ-008 in_ready  out  1  block can accept a beat.
REQ-009 in_first  in  1  beat is first pixel of a window.
REQ-010 pix_a, pix_b  in  PIX_W each  current and reference pixels, unsigned.
REQ-011 threshold  in  SUM_W  hit threshold, sampled on each accepted in_first beat.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_sum  out  SUM_W  sum of |pix_a-pix_b| over the window.
REQ-015 out_hit  out  1  out_sum > sampled threshold.
REQ-016 sync_err  out  1  one-cycle pulse on framing error.

Function
REQ-017 Beat accepted iff in_valid && in_ready at a rising edge.
REQ-018 States: IDLE, ACCUM, DONE; in_ready = 1 in IDLE and ACCUM, = out_ready in DONE.
REQ-019 IDLE: accepted beat with in_first=1 -> acc = |a-b|, count = 1, thr latched, go ACCUM (or DONE if N = 1); in_first=0 -> beat dropped, sync_err pulses, stay IDLE.
REQ-020 ACCUM: accepted beat with in_first=0 -> acc += |a-b|, count += 1; beat making count = N -> go DONE.
REQ-021 ACCUM: accepted beat with in_first=1 -> partial window discarded, sync_err pulses, restart as REQ-019 first-beat case.
REQ-022 |a-b| computed unsigned, exact, zero-extended to SUM_W; no saturation needed (width per REQ-004).
REQ-023 Latency: out_valid SHALL rise the cycle after the N-th beat is accepted, with out_sum and out_hit registered and stable while out_valid = 1.
REQ-024 DONE: out_valid = 1 until out_valid && out_ready; then out_valid falls next cycle unless REQ-025 applies.
REQ-025 Simultaneous handshake in DONE: beat accepted with in_first=1 starts new window (ACCUM) same edge the result is consumed; with in_first=0 beat dropped, sync_err pulses, go IDLE.
REQ-026 out_hit uses threshold latched at window start; threshold changes mid-window ignored.
REQ-027 count width clog2(N+1); no wrap within a window.

Reset
REQ-028 reset asserted -> state IDLE, acc 0, count 0, latched thr 0, out_valid 0, out_sum 0, out_hit 0, sync_err 0, immediately (asynchronous).
REQ-029 Reset mid-window discards partial sum; first post-reset beat needs in_first=1.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Package sad_pkg SHALL hold the state enum, default parameter constants and a clog2 helper.
REQ-032 Sub-module abs_diff (combinational, PIX_W param) SHALL compute |a-b|; everything else lives in window_sad_acc.

Verification
REQ-033 Defaults, 121 beats a=200,b=100, in_first on beat 0, threshold=12000 -> out_sum=12100, out_hit=1, out_valid cycle after beat 121.
REQ-034 Defaults, 121 beats a=0,b=255 -> out_sum=30855 (no overflow), out_hit=1 for threshold=0.
REQ-035 in_first reasserted at beat 50 of a window -> sync_err one cycle, out_sum reflects only the 121 beats from the restart.
REQ-036 out_ready held low 10 cycles -> out_valid/out_sum stable, in_ready=0; then out_ready=1 with in_valid/in_first=1 -> back-to-back window, no beat lost.
REQ-037 reset pulsed at beat 60 -> all outputs 0 at once; beats without in_first afterwards dropped with sync_err.
REQ-038 WIN_W=2, WIN_H=2, PIX_W=8, SUM_W=10, a-b = 1,2,3,4 (some with b>a) -> out_sum=10.
